// File: rtl/prng_pkg.sv
// Shared types, default LFSR constants and the round-robin pick function
// for the PRNG arbiter and its helpers.
package prng_pkg;

    localparam int unsigned DEF_NBITS = 16;
    localparam int unsigned DEF_WORD  = 8;
    localparam logic [15:0] DEF_TAPS  = 16'b0000000000011101;

    localparam int unsigned MAX_REQ  = 8;
    localparam int unsigned MAX_IDXW = 3;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_IDXW-1:0] idx;
    } rr_pick_t;

    // First set request scanning upward from rr+1, wrapping modulo nreq.
    function automatic rr_pick_t rr_pick_f(
        input logic [MAX_REQ-1:0]  req,
        input logic [MAX_IDXW-1:0] rr,
        input int unsigned         nreq
    );
        rr_pick_t    r;
        int unsigned i;
        r = '0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            i = (32'(rr) + k) % nreq;
            if (k <= nreq && !r.valid && req[MAX_IDXW'(i)]) begin
                r.valid = 1'b1;
                r.idx   = MAX_IDXW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr.sv
// Galois LFSR, shifting left; synchronous reset loads all ones.
// Exports the low OUTW bits of the next state so callers can register them.
module lfsr #(
    parameter int unsigned      NBITS = 16,
    parameter logic [NBITS-1:0] TAPS  = NBITS'(16'h001D),
    parameter int unsigned      OUTW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    output logic [OUTW-1:0] out_next_c
);

    logic [NBITS-1:0] value;
    logic [NBITS-1:0] value_next;

    always_comb begin
        value_next = {value[NBITS-2:0], 1'b0};
        if (value[NBITS-1]) begin
            value_next = value_next ^ TAPS;
        end
        out_next_c = value_next[OUTW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '1;
        end else if (en) begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector; reusable by other arbiters.
module rr_pick
    import prng_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] rr,
    output logic [$clog2(NREQ)-1:0] idx_c,
    output logic                    valid_c
);

    localparam int unsigned IDXW = $clog2(NREQ);

    rr_pick_t pick;

    always_comb begin
        pick    = rr_pick_f(MAX_REQ'(req), MAX_IDXW'(rr), NREQ);
        idx_c   = IDXW'(pick.idx);
        valid_c = pick.valid;
    end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one LFSR among NREQ requesters, one WORD per grant.
// Build option PRNG_IDLE_RUN_EN: also clock the LFSR in every IDLE cycle.
module prng_arbiter
    import prng_pkg::*;
#(
    parameter int unsigned      NREQ  = 4,
    parameter int unsigned      WORD  = DEF_WORD,
    parameter int unsigned      NBITS = DEF_NBITS,
    parameter logic [NBITS-1:0] TAPS  = NBITS'(DEF_TAPS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    output logic [NREQ-1:0]         ack,
    output logic [WORD-1:0]         data,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_idx
);

    localparam int unsigned     IDXW       = $clog2(NREQ);
    localparam int unsigned     CNTW       = $clog2(NBITS);
    localparam logic [CNTW-1:0] INIT_LAST  = CNTW'(NBITS - 1);
    localparam logic [CNTW-1:0] SHIFT_LAST = CNTW'(WORD - 1);
    localparam logic [IDXW-1:0] RR_RESET   = IDXW'(NREQ - 1);

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [IDXW-1:0]   rr_q, rr_d;
    logic [IDXW-1:0]   grant_d;
    logic [NREQ-1:0]   ack_d;
    logic [WORD-1:0]   data_d;
    logic              busy_d;

    logic              lfsr_rst_c;
    logic              lfsr_en_c;
    logic [WORD-1:0]   lfsr_word_c;
    logic [IDXW-1:0]   pick_idx_c;
    logic              pick_valid_c;

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req     (req),
        .rr      (rr_q),
        .idx_c   (pick_idx_c),
        .valid_c (pick_valid_c)
    );

    lfsr #(
        .NBITS (NBITS),
        .TAPS  (TAPS),
        .OUTW  (WORD)
    ) u_lfsr (
        .clk        (clk),
        .reset      (lfsr_rst_c),
        .en         (lfsr_en_c),
        .out_next_c (lfsr_word_c)
    );

    // Held in reseed for the whole INIT window so every run starts from all ones.
    assign lfsr_rst_c = reset || (state_q == INIT);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        grant_d   = grant_idx;
        ack_d     = '0;
        data_d    = '0;
        busy_d    = 1'b1;
        lfsr_en_c = 1'b0;

        case (state_q)
            INIT: begin
                if (cnt_q == INIT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            IDLE: begin
                busy_d = 1'b0;
`ifdef PRNG_IDLE_RUN_EN
                lfsr_en_c = 1'b1;
`endif
                if (pick_valid_c) begin
                    grant_d = pick_idx_c;
                    rr_d    = pick_idx_c;
                    state_d = SHIFT;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                lfsr_en_c = 1'b1;
                if (cnt_q == SHIFT_LAST) begin
                    // Capture the word produced by this final step for the DONE cycle.
                    state_d = DONE;
                    cnt_d   = '0;
                    ack_d   = NREQ'(1) << grant_idx;
                    data_d  = lfsr_word_c;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            rr_q      <= RR_RESET;
            grant_idx <= '0;
            ack       <= '0;
            data      <= '0;
            busy      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            grant_idx <= grant_d;
            ack       <= ack_d;
            data      <= data_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed bench for prng_arbiter: reseed window, word values, rotation, reset abort.
module tb_prng_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] ack;
    logic [7:0] data;
    logic       busy;
    logic [1:0] grant_idx;

    int n_checks = 0;
    int n_pass   = 0;

    prng_arbiter #(
        .NREQ  (4),
        .WORD  (8),
        .NBITS (16),
        .TAPS  (16'b0000000000011101)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ack       (ack),
        .data      (data),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until an ack appears or the budget runs out; n = cycles taken.
    task automatic wait_ack(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ack == 4'b0000 && n < budget);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int e;
        logic [7:0] rr_words [2];
        rr_words[0] = 8'h00;
        rr_words[1] = 8'hB4;

        reset = 1'b1;
        req   = 4'b0000;
        repeat (3) tick();
        check("rst_ack",   ack,       4'b0000);
        check("rst_data",  data,      8'h00);
        check("rst_busy",  busy,      1'b1);
        check("rst_grant", grant_idx, 2'd0);

        // INIT: 16 busy cycles, requests ignored
        reset = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            check("init_busy", busy, 1'b1);
            check("init_ack",  ack,  4'b0000);
            if (i == 15) req = 4'b0000;
            tick();
        end
        check("idle_busy", busy, 1'b0);
        tick();
        check("idle_busy2", busy, 1'b0);
        check("idle_ack",   ack,  4'b0000);

        // First word for requester 0
        req = 4'b0001;
        wait_ack(20, n);
        check("w1_lat",   n,                  9);
        check("w1_ack",   ack,                4'b0001);
        check("w1_data",  data,               8'h0B);
        check("w1_grant", grant_idx,          2'd0);
        check("w1_lfsr",  dut.u_lfsr.value,   16'hF40B);
        check("w1_busy",  busy,               1'b1);
        req = 4'b0000;
        tick();
        check("w1_ack_off",  ack,  4'b0000);
        check("w1_data_off", data, 8'h00);
        check("w1_busy_off", busy, 1'b0);

        // Second word, requester 0 again
        req = 4'b0001;
        wait_ack(20, n);
        check("w2_lat",  n,                9);
        check("w2_ack",  ack,              4'b0001);
        check("w2_data", data,             8'hC4);
        check("w2_lfsr", dut.u_lfsr.value, 16'h00C4);
        req = 4'b0000;
        tick();

        // All requesting: rotation continues from last grant (0)
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            e = (k + 1) % 4;
            wait_ack(20, n);
            check("rr_lat",   n,         (k == 0) ? 9 : 8);
            check("rr_ack",   ack,       32'(4'b0001 << e));
            check("rr_grant", grant_idx, 32'(e));
            if (k < 2) check("rr_data", data, rr_words[k]);
            if (k < 4) begin
                tick();
                req[e] = 1'b0;
                tick();
                req[e] = 1'b1;
            end else begin
                req = 4'b0000;
                tick();
            end
        end

        // One-cycle pulse on req[2] is still served
        req = 4'b0100;
        tick();
        req = 4'b0000;
        wait_ack(20, n);
        check("pulse_lat", n,   8);
        check("pulse_ack", ack, 4'b0100);
        req = 4'b1011;
        wait_ack(20, n);
        check("after_pulse_lat",   n,         10);
        check("after_pulse_ack",   ack,       4'b1000);
        check("after_pulse_grant", grant_idx, 2'd3);
        req = 4'b0000;
        tick();

        // Reset in the middle of SHIFT, request held across it
        req = 4'b0010;
        repeat (5) tick();
        check("mid_busy", busy,          1'b1);
        check("mid_cnt",  dut.cnt_q,     4'd4);
        reset = 1'b1;
        tick();
        check("abort_ack",  ack,  4'b0000);
        check("abort_busy", busy, 1'b1);
        tick();
        reset = 1'b0;
        wait_ack(40, n);
        check("reseed_lat",   n,         25);
        check("reseed_ack",   ack,       4'b0010);
        check("reseed_data",  data,      8'h0B);
        check("reseed_grant", grant_idx, 2'd1);
        req = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
